// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Purpose  : Default VGA geometry, derived sync widths and lock FSM encoding.
// Revision : 1.0
// ============================================================================
package vga_pkg;

    function automatic int sync_width(input int total, input int active,
                                      input int front, input int back);
        return total - active - front - back;
    endfunction

    localparam int c_DEF_VIDEO_WIDTH = 3;
    localparam int c_DEF_TOTAL_COLS  = 800;
    localparam int c_DEF_TOTAL_ROWS  = 525;
    localparam int c_DEF_ACTIVE_COLS = 640;
    localparam int c_DEF_ACTIVE_ROWS = 480;
    localparam int c_DEF_H_FRONT     = 18;
    localparam int c_DEF_H_BACK      = 50;
    localparam int c_DEF_V_FRONT     = 10;
    localparam int c_DEF_V_BACK      = 33;

    // 92 clocks and 2 lines for the default geometry
    localparam int c_DEF_H_SYNC = sync_width(c_DEF_TOTAL_COLS, c_DEF_ACTIVE_COLS,
                                             c_DEF_H_FRONT, c_DEF_H_BACK);
    localparam int c_DEF_V_SYNC = sync_width(c_DEF_TOTAL_ROWS, c_DEF_ACTIVE_ROWS,
                                             c_DEF_V_FRONT, c_DEF_V_BACK);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Two-flop synchronizer for an active-low sync pulse plus a
//            falling-edge detector on the synchronized stage.
// Revision : 1.0
// ============================================================================
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_fall
);

    logic r_meta_q, r_sync_q, r_prev_q;
    logic w_meta_d, w_sync_d, w_prev_d;

    always_comb begin
        w_meta_d = i_async;
        w_sync_d = r_meta_q;
        w_prev_d = r_sync_q;
    end

    // Idle level of a sync line is high, so reset never fakes an edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta_q <= 1'b1;
            r_sync_q <= 1'b1;
            r_prev_q <= 1'b1;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
            r_prev_q <= w_prev_d;
        end
    end

    assign o_fall = r_prev_q & ~r_sync_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Purpose  : Recovers VGA timing from asynchronous sync pulses, locks to the
//            expected geometry and emits DE, active coordinates and video.
//            Define VGA_DEC_MEASURE_EN to expose measured line/frame lengths.
// Revision : 1.0
// ============================================================================
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH = c_DEF_VIDEO_WIDTH,
    parameter int TOTAL_COLS  = c_DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS  = c_DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS = c_DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = c_DEF_ACTIVE_ROWS,
    parameter int H_FRONT     = c_DEF_H_FRONT,
    parameter int H_BACK      = c_DEF_H_BACK,
    parameter int V_FRONT     = c_DEF_V_FRONT,
    parameter int V_BACK      = c_DEF_V_BACK
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic [VIDEO_WIDTH-1:0] i_red_video,
    input  logic [VIDEO_WIDTH-1:0] i_green_video,
    input  logic [VIDEO_WIDTH-1:0] i_blue_video,
    output logic                   o_de,
    output logic [9:0]             o_col_count,
    output logic [9:0]             o_row_count,
    output logic [VIDEO_WIDTH-1:0] o_red_video,
    output logic [VIDEO_WIDTH-1:0] o_green_video,
    output logic [VIDEO_WIDTH-1:0] o_blue_video,
    output logic                   o_locked,
    output logic [10:0]            o_line_period,
    output logic [9:0]             o_frame_lines
);

    localparam int c_H_SYNC = sync_width(TOTAL_COLS, ACTIVE_COLS, H_FRONT, H_BACK);
    localparam int c_V_SYNC = sync_width(TOTAL_ROWS, ACTIVE_ROWS, V_FRONT, V_BACK);
    localparam int c_PIX_W  = 3 * VIDEO_WIDTH;

    localparam logic [10:0] c_H_START   = 11'(c_H_SYNC + H_BACK);
    localparam logic [10:0] c_H_END     = 11'(c_H_SYNC + H_BACK + ACTIVE_COLS);
    localparam logic [9:0]  c_V_START   = 10'(c_V_SYNC + V_BACK);
    localparam logic [9:0]  c_V_END     = 10'(c_V_SYNC + V_BACK + ACTIVE_ROWS);
    localparam logic [10:0] c_H_SAT     = 11'(2 * TOTAL_COLS - 1);
    localparam logic [10:0] c_LINE_LEN  = 11'(TOTAL_COLS);
    localparam logic [9:0]  c_FRAME_LEN = 10'(TOTAL_ROWS);
    localparam logic [9:0]  c_V_MAX     = 10'h3FF;

    logic w_hs_fall, w_vs_fall;

    sync_edge_detect u_hs_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_hsync),
        .o_fall  (w_hs_fall)
    );

    sync_edge_detect u_vs_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_vsync),
        .o_fall  (w_vs_fall)
    );

    lock_state_e        r_state_q, w_state_d;
    logic               r_h_valid_q, w_h_valid_d;
    logic [10:0]        r_h_cnt_q, w_h_cnt_d;
    logic [9:0]         r_v_cnt_q, w_v_cnt_d;
    logic [c_PIX_W-1:0] r_vid1_q, w_vid1_d;
    logic [c_PIX_W-1:0] r_vid2_q, w_vid2_d;
    logic [c_PIX_W-1:0] r_pix_q, w_pix_d;
    logic               r_de_q, w_de_d;
    logic [9:0]         r_col_q, w_col_d;
    logic [9:0]         r_row_q, w_row_d;

    logic [10:0] w_period;
    logic [9:0]  w_frame;
    logic        w_period_bad, w_frame_ok, w_h_sat;

    always_comb begin
        w_period     = r_h_cnt_q + 11'd1;
        w_frame      = (w_hs_fall && (r_v_cnt_q != c_V_MAX)) ? r_v_cnt_q + 10'd1 : r_v_cnt_q;
        w_period_bad = w_hs_fall && (w_period != c_LINE_LEN);
        w_frame_ok   = (w_frame == c_FRAME_LEN);
        w_h_sat      = (r_h_cnt_q == c_H_SAT);
    end

    always_comb begin
        w_h_cnt_d = r_h_cnt_q;
        if (w_hs_fall) begin
            w_h_cnt_d = '0;
        end else if (!w_h_sat) begin
            w_h_cnt_d = r_h_cnt_q + 11'd1;
        end

        w_v_cnt_d = r_v_cnt_q;
        if (w_vs_fall) begin
            w_v_cnt_d = '0;
        end else if (w_hs_fall && (r_v_cnt_q != c_V_MAX)) begin
            w_v_cnt_d = r_v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_h_valid_d = r_h_valid_q | w_hs_fall;
        case (r_state_q)
            ST_UNLOCKED: begin
                if (w_vs_fall && (r_h_valid_q || w_hs_fall)) begin
                    w_state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_period_bad) begin
                    w_state_d = ST_UNLOCKED;
                end else if (w_vs_fall) begin
                    w_state_d = w_frame_ok ? ST_LOCKED : ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_period_bad || (w_vs_fall && !w_frame_ok) || w_h_sat) begin
                    w_state_d   = ST_UNLOCKED;
                    w_h_valid_d = 1'b0;
                end
            end
            default: begin
                w_state_d = ST_UNLOCKED;
            end
        endcase
    end

    // Outputs register from next-state counters so they line up with the
    // two-stage video delay: pin to output is three flops on every path.
    always_comb begin
        w_vid1_d = {i_red_video, i_green_video, i_blue_video};
        w_vid2_d = r_vid1_q;
        w_de_d   = (w_state_d == ST_LOCKED)
                && (w_h_cnt_d >= c_H_START) && (w_h_cnt_d < c_H_END)
                && (w_v_cnt_d >= c_V_START) && (w_v_cnt_d < c_V_END);
        w_col_d  = '0;
        w_row_d  = '0;
        w_pix_d  = '0;
        if (w_de_d) begin
            w_col_d = 10'(w_h_cnt_d - c_H_START);
            w_row_d = w_v_cnt_d - c_V_START;
            w_pix_d = r_vid2_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= ST_UNLOCKED;
            r_h_valid_q <= 1'b0;
            r_h_cnt_q   <= '0;
            r_v_cnt_q   <= '0;
            r_vid1_q    <= '0;
            r_vid2_q    <= '0;
            r_pix_q     <= '0;
            r_de_q      <= 1'b0;
            r_col_q     <= '0;
            r_row_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_h_valid_q <= w_h_valid_d;
            r_h_cnt_q   <= w_h_cnt_d;
            r_v_cnt_q   <= w_v_cnt_d;
            r_vid1_q    <= w_vid1_d;
            r_vid2_q    <= w_vid2_d;
            r_pix_q     <= w_pix_d;
            r_de_q      <= w_de_d;
            r_col_q     <= w_col_d;
            r_row_q     <= w_row_d;
        end
    end

    assign o_de          = r_de_q;
    assign o_col_count   = r_col_q;
    assign o_row_count   = r_row_q;
    assign o_red_video   = r_pix_q[c_PIX_W-1 -: VIDEO_WIDTH];
    assign o_green_video = r_pix_q[2*VIDEO_WIDTH-1 -: VIDEO_WIDTH];
    assign o_blue_video  = r_pix_q[VIDEO_WIDTH-1:0];
    assign o_locked      = (r_state_q == ST_LOCKED);

`ifdef VGA_DEC_MEASURE_EN
    logic [10:0] r_line_period_q, w_line_period_d;
    logic [9:0]  r_frame_lines_q, w_frame_lines_d;

    always_comb begin
        w_line_period_d = w_hs_fall ? w_period : r_line_period_q;
        w_frame_lines_d = w_vs_fall ? w_frame : r_frame_lines_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_line_period_q <= '0;
            r_frame_lines_q <= '0;
        end else begin
            r_line_period_q <= w_line_period_d;
            r_frame_lines_q <= w_frame_lines_d;
        end
    end

    assign o_line_period = r_line_period_q;
    assign o_frame_lines = r_frame_lines_q;
`else
    assign o_line_period = '0;
    assign o_frame_lines = '0;
`endif

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have parameter VIDEO_WIDTH, default 3, meaning bits per colour channel.
REQ-002 The block SHALL have parameters TOTAL_COLS 800, TOTAL_ROWS 525, ACTIVE_COLS 640, ACTIVE_ROWS 480, meaning the expected VGA frame geometry in clocks and lines.
REQ-003 The block SHALL have parameters H_FRONT 18, H_BACK 50, V_FRONT 10, V_BACK 33, meaning porch lengths; sync width is derived as H_SYNC = 92 and V_SYNC = 2.
REQ-004 i_clk  in  1  pixel clock (25 MHz class); the block SHALL use one clock.
REQ-005 i_rst  in  1  reset; the block SHALL use a synchronous, active-high reset.
REQ-006 i_hsync, i_vsync  in  1 each  active-low sync pulses, asynchronous to i_clk.
REQ-007 i_red_video, i_green_video, i_blue_video  in  VIDEO_WIDTH each  pixel data.
REQ-008 o_de  out  1  active-video strobe.
REQ-009 o_col_count  out  10  active column 0..639; o_row_count  out  10  active row 0..479.
REQ-010 o_red_video, o_green_video, o_blue_video  out  VIDEO_WIDTH each  pixel data aligned to o_de.
REQ-011 o_locked  out  1  timing lock; o_line_period  out  11  and o_frame_lines  out  10  carry measured timing.

Function
REQ-012 Sync inputs SHALL pass through a 2-flop synchronizer; video inputs SHALL be delayed 2 flops to match.
REQ-013 A falling edge SHALL be detected on the synchronized stage; this is the start of a sync pulse.
REQ-014 The horizontal counter h_cnt (11 bit) SHALL load 0 the cycle after an hsync falling edge; otherwise it SHALL increment, saturating at 2*TOTAL_COLS-1.
REQ-015 v_cnt SHALL load 0 on a vsync falling edge, with vsync taking priority over a coincident hsync edge; otherwise it SHALL increment on each hsync falling edge.
REQ-016 At each hsync falling edge the measured period SHALL be h_cnt+1; at each vsync falling edge the measured frame lines SHALL be v_cnt+1 if an hsync edge is coincident, else v_cnt.
REQ-017 Active region SHALL be h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+ACTIVE_COLS) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+ACTIVE_ROWS).
REQ-018 o_de SHALL be 1 only when in the active region and in LOCKED; o_col_count and o_row_count SHALL then be offsets from the region start, and 0 otherwise.
REQ-019 Latency from input pin to o_de and video outputs SHALL be exactly 3 cycles.
REQ-020 While o_de=0, video outputs SHALL be driven to 0.
REQ-021 The lock FSM states SHALL be UNLOCKED, TRACK and LOCKED.
REQ-022 UNLOCKED SHALL go to TRACK on a vsync falling edge, provided an hsync edge has been seen since reset or loss (h_valid).
REQ-023 In TRACK, a line period != TOTAL_COLS SHALL go to UNLOCKED; a vsync edge with frame lines == TOTAL_ROWS SHALL go to LOCKED; a vsync edge with frame lines != TOTAL_ROWS SHALL go to UNLOCKED.
REQ-024 In LOCKED, any period or frame mismatch, or h_cnt saturation (no hsync for 1600 clocks), SHALL go to UNLOCKED the next cycle and clear h_valid.
REQ-025 o_locked SHALL be 1 only in LOCKED; when entering UNLOCKED mid-line, o_de SHALL drop the next cycle.

Reset
REQ-026 On reset, all outputs SHALL be 0, the FSM SHALL be in UNLOCKED, h_valid and the counters SHALL be 0, and the synchronizers SHALL be 1 (sync idle high).
REQ-027 Reset asserted mid-frame SHALL take effect at the next clock edge; relock SHALL require a full frame.

Configuration
REQ-028 With VGA_DEC_MEASURE_EN defined, o_line_period and o_frame_lines SHALL register the last measured values, updated at their edges.
REQ-029 Without VGA_DEC_MEASURE_EN, both outputs SHALL be tied to 0; lock behaviour SHALL be unchanged.

Structure
REQ-030 Geometry defaults, derived sync widths and FSM state encodings SHALL live in package vga_pkg.
REQ-031 The 2-flop synchronizer and falling-edge detector SHALL be one sub-module, sync_edge_detect, instantiated twice.

Verification
REQ-032 The bench SHALL drive standard 800x525 sync for 2 frames -> o_locked=1 at the end of the first full frame after the first vsync; 640 o_de pulses per line; 480 lines per frame.
REQ-033 The bench SHALL drive a pixel pattern equal to the column number -> o_red_video equals o_col_count[2:0], 3 cycles after the input.
REQ-034 The bench SHALL change one line to 801 clocks while LOCKED -> o_locked=0 at the next cycle; relock after 2 clean vsyncs; o_line_period=801 with the macro.
REQ-035 The bench SHALL hold hsync high for 1600 clocks while LOCKED -> o_locked=0 and o_de=0.
REQ-036 The bench SHALL drive a 524-line frame -> no lock; o_frame_lines=524 with the macro, 0 without it.
REQ-037 The bench SHALL assert i_rst mid-active-line -> all outputs 0 the next cycle; lock regained only after a full valid frame.
